// File: rtl/multicycle_controller.sv
// Control FSM for a shared-ALU, unified-memory multicycle ARM datapath.
// Holds NZCV, gates writes on the instruction's condition and issues per-cycle selects.
module multicycle_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [19:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         RegSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned ENC_W = 4;

  typedef enum logic [ENC_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q;
  logic       condex_q, condex_d;
  logic       cond_ex;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       rd_pc;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign rd_pc     = (rd == 4'hF);
  assign unused_rn = ^Instr[7:4];

  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign ImmSrc = op;
  assign state  = STATE_W'(state_q);

  // Condition check against the architectural flag register.
  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // ALU command decode; unknown commands become NOPs.
  logic [2:0] alu_dec;
  logic       cmd_ok;
  logic       cmd_arith;

  always_comb begin
    alu_dec   = 3'b000;
    cmd_ok    = 1'b1;
    cmd_arith = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_dec = 3'b000; cmd_arith = 1'b1; end
      4'b0010: begin alu_dec = 3'b001; cmd_arith = 1'b1; end
      4'b0000: alu_dec = 3'b010;
      4'b1100: alu_dec = 3'b011;
      default: cmd_ok = 1'b0;
    endcase
  end

  logic       pc_write_d, mem_write_d, reg_write_d, ir_write_d, adr_src_d, alu_src_a_d;
  logic [1:0] alu_src_b_d, result_src_d;
  logic [2:0] alu_control_d;

  // Next state, plus the outputs of that next state so they can be registered.
  always_comb begin
    state_d       = state_q;
    condex_d      = condex_q;
    pc_write_d    = 1'b0;
    mem_write_d   = 1'b0;
    reg_write_d   = 1'b0;
    ir_write_d    = 1'b0;
    adr_src_d     = 1'b0;
    alu_src_a_d   = 1'b0;
    alu_src_b_d   = 2'b00;
    result_src_d  = 2'b00;
    alu_control_d = 3'b000;

    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        condex_d = cond_ex;
        case (op)
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR,
      EXECI:  state_d = ALUWB;
      default: state_d = FETCH;
    endcase

    case (state_d)
      FETCH: begin
        ir_write_d   = 1'b1;
        alu_src_a_d  = 1'b1;
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
        pc_write_d   = 1'b1;
      end
      DECODE: begin
        alu_src_a_d  = 1'b1;
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
      end
      MEMADR: alu_src_b_d = 2'b01;
      MEMRD:  adr_src_d = 1'b1;
      MEMWR: begin
        adr_src_d   = 1'b1;
        mem_write_d = condex_d;
      end
      MEMWB: begin
        result_src_d = 2'b01;
        reg_write_d  = condex_d & ~rd_pc;
      end
      EXECR: alu_control_d = alu_dec;
      EXECI: begin
        alu_src_b_d   = 2'b01;
        alu_control_d = alu_dec;
      end
      ALUWB:  reg_write_d = condex_d & cmd_ok & ~rd_pc;
      BRANCH: begin
        alu_src_b_d  = 2'b01;
        result_src_d = 2'b10;
        pc_write_d   = condex_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      condex_q   <= 1'b0;
      PCWrite    <= 1'b1;
      MemWrite   <= 1'b0;
      RegWrite   <= 1'b0;
      IRWrite    <= 1'b1;
      AdrSrc     <= 1'b0;
      ALUSrcA    <= 1'b1;
      ALUSrcB    <= 2'b10;
      ResultSrc  <= 2'b10;
      ALUControl <= 3'b000;
    end else begin
      state_q    <= state_d;
      condex_q   <= condex_d;
      PCWrite    <= pc_write_d;
      MemWrite   <= mem_write_d;
      RegWrite   <= reg_write_d;
      IRWrite    <= ir_write_d;
      AdrSrc     <= adr_src_d;
      ALUSrcA    <= alu_src_a_d;
      ALUSrcB    <= alu_src_b_d;
      ResultSrc  <= result_src_d;
      ALUControl <= alu_control_d;
    end
  end

  // S-suffixed ops update N/Z always; C/V only for ADD/SUB.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if ((state_q == EXECR || state_q == EXECI) && funct[0] && condex_q && cmd_ok) begin
      flags_q[3:2] <= ALUFlags[3:2];
      if (cmd_arith) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized and directed bench for multicycle_controller against an
// instruction-level reference model (flags, condition, per-class state sequences).
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  state;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0]  mflags;
  logic [19:0] cur_ins;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // ARM condition: even code tests a predicate, odd code tests its negation.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // {valid, arith, code} for a data-processing cmd field.
  function automatic logic [4:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 5'b11_000;
      4'b0010: return 5'b11_001;
      4'b0000: return 5'b10_010;
      4'b1100: return 5'b10_011;
      default: return 5'b00_000;
    endcase
  endfunction

  function automatic logic [16:0] dut_vec();
    return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
            ALUSrcB, ResultSrc, ImmSrc, ALUControl};
  endfunction

  // Expected control word for a state, from the per-state output table.
  function automatic logic [16:0] exp_vec(input int st, input bit cx, input logic [19:0] ins);
    logic pc = 0, mw = 0, rw = 0, ir = 0, adr = 0, sa = 0;
    logic [1:0] sb = 0, rs = 0, op;
    logic [2:0] alu = 0;
    logic [4:0] d;
    bit rd15;
    op   = ins[15:14];
    rd15 = (ins[3:0] == 4'hF);
    d    = alu_decode(ins[12:9]);
    case (st)
      0: begin pc = 1; ir = 1; sa = 1; sb = 2'b10; rs = 2'b10; end
      1: begin sa = 1; sb = 2'b10; rs = 2'b10; end
      2: sb = 2'b01;
      3: adr = 1;
      4: begin rs = 2'b01; rw = cx && !rd15; end
      5: begin adr = 1; mw = cx; end
      6: alu = d[2:0];
      7: begin sb = 2'b01; alu = d[2:0]; end
      8: rw = cx && d[4] && !rd15;
      9: begin sb = 2'b01; rs = 2'b10; pc = cx; end
      default: ;
    endcase
    return {pc, mw, rw, ir, adr, op == 2'b01, op == 2'b10, sa, sb, rs, op, alu};
  endfunction

  // Runs one instruction from FETCH; abort_at>=0 asserts reset after that step.
  task automatic run_instr(input logic [19:0] ins, input logic [3:0] exec_flags, input int abort_at);
    int  seq[$];
    bit  cx;
    logic [4:0] d;
    cx = cond_holds(ins[19:16], mflags);
    d  = alu_decode(ins[12:9]);
    case (ins[15:14])
      2'b00:   seq = ins[13] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
      2'b01:   seq = ins[8] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
      2'b10:   seq = '{0, 1, 9};
      default: seq = '{0, 1};
    endcase
    for (int k = 0; k < seq.size(); k++) begin
      check($sformatf("state[%0d]", k), 32'(state), 32'(seq[k]));
      check($sformatf("ctrl[%0d] st%0d", k, seq[k]), 32'(dut_vec()), 32'(exp_vec(seq[k], cx, cur_ins)));
      if (k == abort_at) begin
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        mflags = 4'b0000;
        check("rst state", 32'(state), 32'd0);
        check("rst ctrl", 32'(dut_vec()), 32'(exp_vec(0, 1'b0, cur_ins)));
        reset = 1'b0;
        return;
      end
      if (seq[k] == 6 || seq[k] == 7) begin
        ALUFlags = exec_flags;
        if (ins[8] && cx && d[4]) begin
          mflags[3:2] = exec_flags[3:2];
          if (d[3]) mflags[1:0] = exec_flags[1:0];
        end
      end else begin
        ALUFlags = 4'($urandom);
      end
      if (k == 0) begin
        Instr   = ins;
        cur_ins = ins;
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    logic [19:0] r;
    reset    = 1'b1;
    Instr    = '0;
    cur_ins  = '0;
    ALUFlags = '0;
    mflags   = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", 32'(state), 32'd0);
    check("reset ctrl", 32'(dut_vec()), 32'(exp_vec(0, 1'b0, cur_ins)));
    reset = 1'b0;

    run_instr(20'hE0812, 4'h0, -1);   // ADD R2,R1,R3
    run_instr(20'hE2510, 4'b0100, -1);// SUBS -> Z
    run_instr(20'h0A000, 4'h0, -1);   // BEQ taken
    run_instr(20'hE2510, 4'b0000, -1);// SUBS -> clear
    run_instr(20'h0A000, 4'h0, -1);   // BEQ not taken
    run_instr(20'hE5912, 4'h0, -1);   // LDR
    run_instr(20'hE5812, 4'h0, -1);   // STR
    run_instr(20'hE2901, 4'b0011, -1);// ADDS -> C,V
    run_instr(20'hE2101, 4'b1000, -1);// ANDS -> 1011
    run_instr(20'h4A000, 4'h0, -1);   // BMI
    run_instr(20'h6A000, 4'h0, -1);   // BVS
    run_instr(20'h0A000, 4'h0, -1);   // BEQ not taken
    run_instr(20'hE2510, 4'b0100, -1);// SUBS -> Z
    run_instr(20'h12901, 4'b1111, -1);// ADDSNE suppressed
    run_instr(20'h0A000, 4'h0, -1);   // BEQ still taken
    run_instr(20'hE5812, 4'h0, 3);    // STR aborted in MEMWR
    run_instr(20'hEC000, 4'h0, -1);   // illegal op
    run_instr(20'hE080F, 4'h0, -1);   // ADD to R15 suppressed
    run_instr(20'hE591F, 4'h0, -1);   // LDR to R15 suppressed

    for (int i = 0; i < 300; i++) begin
      r = 20'($urandom);
      if ($urandom_range(0, 1) == 0) r[19:16] = 4'hE;
      if (r[3:0] == 4'hF && $urandom_range(0, 3) != 0) r[3:0] = 4'h1;
      run_instr(r, 4'($urandom), ($urandom_range(0, 29) == 0) ? 2 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a shared-ALU, unified-memory multicycle ARM datapath.
- Each instruction runs over 3–5 cycles.
- Decodes Instr[31:12] latched in the datapath IR, keeps the NZCV flag register, evaluates the condition field, and issues per-cycle mux selects and write enables.
- Supported instructions: data-processing (ADD, SUB, AND, ORR; reg/imm), LDR/STR (imm offset) and B.

Parameters:
- STATE_W, 4, width of state/debug encoding.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- Instr  in  20  IR bits [31:12]: Cond[19:16], Op[15:14], Funct[13:8], Rd[3:0]
- ALUFlags  in  4  NZCV from the ALU this cycle
- PCWrite  out  1  PC register enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALU result reg
- RegSrc  out  2  [0]=1 selects R15 as RA1 (branch); [1]=1 selects Rd as RA2 (store)
- ALUSrcA  out  1  0=RD1 reg, 1=PC
- ALUSrcB  out  2  00=RD2 reg, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALU direct
- ImmSrc  out  2  equals Op
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 orr
- state  out  STATE_W  current state (debug)

Behaviour:
State encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.

Reset:
- On reset, state=FETCH, flags=0000, condex_q=0.
- All outputs take their FETCH values on the cycle after reset.
- Reset asserted mid-instruction aborts it; no write enable is asserted in the reset cycle's outputs beyond FETCH values.

Per-state outputs (unlisted outputs = 0):
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=000, ResultSrc=10.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=000.
- MEMRD: AdrSrc=1.
- MEMWR: AdrSrc=1, MemWrite=condex_q.
- MEMWB: ResultSrc=01, RegWrite=condex_q.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUControl=decoded.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUControl=decoded.
- ALUWB: ResultSrc=00, RegWrite=condex_q.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=000, ResultSrc=10, PCWrite=condex_q.
- RegSrc and ImmSrc are combinational from Op in every state: RegSrc[0]=(Op==10), RegSrc[1]=(Op==01).

Transitions:
- FETCH→DECODE.
- DECODE→MEMADR if Op=01; EXECI if Op=00 and Funct[5]=1; EXECR if Op=00 and Funct[5]=0; BRANCH if Op=10; FETCH if Op=11 (illegal, executes as NOP).
- MEMADR→MEMRD if Funct[0]=1, else MEMWR.
- MEMRD→MEMWB.
- EXECR/EXECI→ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH→FETCH.

Latency:
- DP = 4 cycles, LDR = 5, STR = 4, B = 3, illegal = 2.

Condition evaluation:
- CondEx is combinational from Cond and the flag register.
- Codes: EQ 0000 Z, NE 0001 !Z, CS 0010 C, CC 0011 !C, MI 0100 N, PL 0101 !N, VS 0110 V, VC 0111 !V, HI 1000 C&!Z, LS 1001 !C|Z, GE 1010 N==V, LT 1011 N!=V, GT 1100 !Z&(N==V), LE 1101 Z|(N!=V), AL 1110 1, 1111 → 0.
- condex_q <= CondEx at the end of DECODE; all later states use condex_q.
- Flag updates in EXEC therefore cannot change the instruction's own gating.

ALU decode (EXECR/EXECI only):
- Funct[4:1]: 0100→000, 0010→001, 0000→010, 1100→011; any other cmd → 000 with RegWrite suppressed (treated as NOP).

Flag update (end of EXECR/EXECI, only when Funct[0]=S=1 and condex_q=1):
- N and Z always update.
- C and V update only for ADD/SUB.
- AND/ORR preserve C and V.

R15 handling:
- Writes to R15 (Rd=1111) by DP or LDR are unsupported: RegWrite is forced 0 and the PC is unchanged.

Test Plan:
- Reset held 2 cycles, then released → state=0, IRWrite=1, PCWrite=1, flags=0000; the 2nd cycle after reset shows state=1.
- Instr=E0812003 (ADD R2,R1,R3, AL; bits[31:12]=0xE0812) → states 0,1,6,8,0; RegWrite=1 only in ALUWB; ALUControl=000 in EXECR.
- SUBS, then BEQ: E2510005 with ALUFlags=0100 in EXECI → flags=0100. The following 0A000002 → states 0,1,9; PCWrite=1 in BRANCH. Repeat with flags=0000 → PCWrite=0 in BRANCH.
- LDR E5912004 → states 0,1,2,3,4; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. STR E5812004 → 0,1,2,5; MemWrite=1 only in MEMWR.
- Flag-update gating: ANDS with flags C=1,V=1 and ALUFlags=1000 → flags=1011. NE-conditioned ADDS with Z=1 → no RegWrite, flags unchanged.
- Reset asserted during MEMWR → MemWrite=0 next cycle, state=FETCH. Illegal Op=11 → states 0,1,0 with no writes.
